coupling_mode_ctrl: RTL
=======================

// Module: coupling_mode_ctrl
// PURPOSE
// Front-end coupling controller for the scope sample path. Debounces the AC/DC push buttons and runs the mode FSM.
// In AC mode it measures the input DC offset by averaging 2^CAL_LOG2 samples, then removes that offset from the stream.
// Sits between the ADC serial deserialiser and the display/trigger logic. One output sample per input sample.
// PARAMETERS
// DATA_W           12     sample width, unsigned
// DEBOUNCE_CYCLES  100    cycles a button must be held low before a press event
// CAL_LOG2         4      log2 of the number of samples averaged during calibration (16)
// RECAL_SAMPLES    65536  AC_RUN samples between automatic recalibrations (used only with the macro)
// PORTS
// clk           in   1       system clock, rising edge
// rst_n         in   1       asynchronous active-low reset
// ac_button     in   1       AC request button, active-low (pressed = 0)
// dc_button     in   1       DC request button, active-low
// sample_in     in   DATA_W  raw ADC sample, unsigned
// sample_valid  in   1       sample_in is valid this cycle
// result        out  DATA_W  processed sample, unsigned
// out_valid     out  1       result is valid, single-cycle pulse
// mode_ac       out  1       1 in AC_CAL or AC_RUN
// cal_busy      out  1       1 in AC_CAL
// offset_out    out  DATA_W  current measured offset
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=DC; result, offset_out, accumulator, counters = 0; out_valid, mode_ac, cal_busy = 0.
// - Debounce, per button: counter increments while the button is 0 and saturates at DEBOUNCE_CYCLES.
//   Button = 1 clears the counter.
//   A press event is a 1-cycle pulse on the cycle the counter first reaches DEBOUNCE_CYCLES; at most one per press.
// - Press events in the same cycle: the DC event wins.
// - FSM states: DC, AC_CAL, AC_RUN. A transition takes effect on the clock after the event.
//   DC     : ac_evt -> AC_CAL.
//   AC_CAL : dc_evt -> DC (abort, offset_out unchanged).
//            ac_evt -> restart calibration.
//            After 2^CAL_LOG2 valid samples -> AC_RUN.
//   AC_RUN : dc_evt -> DC.
//            ac_evt -> AC_CAL (recalibrate).
// - Entering AC_CAL clears the accumulator (DATA_W+CAL_LOG2 bits) and the sample count.
// - On the last calibration sample: offset_out <= (acc + sample_in) >> CAL_LOG2, truncated.
//   offset_out changes only at this point, or at reset.
// - Datapath latency: 1 cycle. out_valid is asserted the cycle after sample_valid, in every state.
//   DC     : result = sample_in.
//   AC_CAL : result = 2^(DATA_W-1) (mid-scale, 0x800).
//   AC_RUN : result = clamp(sample_in - offset_out + 2^(DATA_W-1), 0, 2^DATA_W-1).
//            Compute in DATA_W+2 signed bits; no wrap-around.
// - The state used for a sample is the state at the cycle sample_valid is high.
// - result holds its value when out_valid = 0.
// - mode_ac and cal_busy are registered decodes of the FSM state.
// CONFIGURATION
// - COUPLING_AUTO_RECAL_EN defined:
//   AC_RUN counts valid samples. When the count reaches RECAL_SAMPLES, the FSM moves to AC_CAL automatically.
//   The count clears on each entry to AC_RUN.
//   A button event in the same cycle overrides the automatic transition.
// - COUPLING_AUTO_RECAL_EN undefined: no counter is built; AC_RUN persists until a button event.
// TESTING
// - Reset; DC mode, sample_in=0x7A3 with valid -> next cycle result=0x7A3, out_valid=1, mode_ac=0.
// - ac_button low for 99 cycles then high -> no state change.
//   Low for 100 cycles -> AC_CAL, cal_busy=1, result=0x800 on valid samples.
// - 16 calibration samples of 0x400 -> offset_out=0x400, AC_RUN.
//   Then sample 0x480 -> 0x880; sample 0x000 -> 0x400.
// - Clamp checks:
//   offset 0x100, sample 0xFFF -> 0xFFF.
//   offset 0xF00, sample 0x000 -> 0x000.
// - dc_evt after 7 of 16 calibration samples -> DC next cycle, cal_busy=0, offset_out unchanged.
//   Simultaneous ac_evt+dc_evt -> DC.
//   rst_n low mid-calibration -> all outputs 0 immediately.
// - With COUPLING_AUTO_RECAL_EN and RECAL_SAMPLES=32: 32 valid samples in AC_RUN -> cal_busy=1 the following cycle.
//   Without the macro: no change after 100 samples.

Source files
------------

// File: rtl/coupling_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coupling_mode_ctrl
// Description : AC/DC coupling controller for the scope sample path.
//               Debounces the active-low AC/DC buttons, runs the coupling
//               mode FSM (DC / AC_CAL / AC_RUN), measures the input DC offset
//               by averaging 2^CAL_LOG2 samples and removes it in AC_RUN.
//               Optional build macro COUPLING_AUTO_RECAL_EN: periodic
//               automatic recalibration every RECAL_SAMPLES AC_RUN samples.
// Revision    : 1.0 - initial release
// ============================================================================
module coupling_mode_ctrl #(
  parameter int DATA_W          = 12,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CAL_LOG2        = 4,
  parameter int RECAL_SAMPLES   = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ac_button,
  input  logic              dc_button,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic              mode_ac,
  output logic              cal_busy,
  output logic [DATA_W-1:0] offset_out
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ACC_W = DATA_W + CAL_LOG2;

  localparam logic [DB_W-1:0]       DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]       DB_ONE   = DB_W'(1);
  localparam logic [CAL_LOG2-1:0]   CAL_LAST = '1;
  localparam logic [CAL_LOG2-1:0]   CAL_ONE  = CAL_LOG2'(1);
  localparam logic [DATA_W-1:0]     MID_U    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W+1:0] MID_S = {3'b001, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W+1:0] MAX_S = {2'b00, {DATA_W{1'b1}}};

  // Reject parameter sets the datapath is not sized for.
  if (DATA_W < 2 || DEBOUNCE_CYCLES < 1 || CAL_LOG2 < 1 || RECAL_SAMPLES < 2) begin : g_param_check
    $error("coupling_mode_ctrl: unsupported parameter value");
  end

  // --------------------------------------------------------------------------
  // Button debounce: one saturating counter per button, press event is a
  // single pulse on the cycle the counter first reaches DEBOUNCE_CYCLES.
  // Index 0 = AC button, index 1 = DC button.
  // --------------------------------------------------------------------------
  logic [1:0] buttons;
  logic       ac_evt;
  logic       dc_evt;

  assign buttons = {dc_button, ac_button};

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            evt;

    // Count held-low cycles; the pulse fires as the count steps onto the limit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        evt <= 1'b0;
      end else if (buttons[i]) begin
        cnt <= '0;
        evt <= 1'b0;
      end else begin
        evt <= (cnt == DB_MAX - DB_ONE);
        if (cnt != DB_MAX) begin
          cnt <= cnt + DB_ONE;
        end
      end
    end
  end

  assign ac_evt = g_debounce[0].evt;
  assign dc_evt = g_debounce[1].evt;

  // --------------------------------------------------------------------------
  // Mode FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_DC     = 2'd0,
    ST_AC_CAL = 2'd1,
    ST_AC_RUN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                cal_clear;   // enter or restart calibration
  logic                cal_accum;   // fold this sample into the average
  logic                cal_done;    // this sample completes the average
  logic [ACC_W-1:0]    cal_acc;
  logic [ACC_W-1:0]    cal_sum;
  logic [CAL_LOG2-1:0] cal_cnt;
  logic                recal_due;

  assign cal_sum = cal_acc + {{CAL_LOG2{1'b0}}, sample_in};

`ifdef COUPLING_AUTO_RECAL_EN
  localparam int RUN_W = $clog2(RECAL_SAMPLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RECAL_SAMPLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  logic [RUN_W-1:0] run_cnt;

  assign recal_due = sample_valid && (run_cnt == RUN_LAST);

  // AC_RUN sample counter; held at zero outside AC_RUN so every entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state != ST_AC_RUN) begin
      run_cnt <= '0;
    end else if (sample_valid) begin
      run_cnt <= run_cnt + RUN_ONE;
    end
  end
`else
  assign recal_due = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and calibration control; the DC event always wins over AC.
  always_comb begin
    state_nxt = state;
    cal_clear = 1'b0;
    cal_accum = 1'b0;
    cal_done  = 1'b0;
    case (state)
      ST_DC: begin
        if (!dc_evt && ac_evt) begin
          state_nxt = ST_AC_CAL;
          cal_clear = 1'b1;
        end
      end
      ST_AC_CAL: begin
        if (dc_evt) begin
          state_nxt = ST_DC;
        end else if (ac_evt) begin
          cal_clear = 1'b1;
        end else if (sample_valid) begin
          cal_accum = 1'b1;
          if (cal_cnt == CAL_LAST) begin
            cal_done  = 1'b1;
            state_nxt = ST_AC_RUN;
          end
        end
      end
      ST_AC_RUN: begin
        if (dc_evt) begin
          state_nxt = ST_DC;
        end else if (ac_evt || recal_due) begin
          state_nxt = ST_AC_CAL;
          cal_clear = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_DC;
      end
    endcase
  end

  // Calibration accumulator, sample count and the published offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_acc    <= '0;
      cal_cnt    <= '0;
      offset_out <= '0;
    end else begin
      if (cal_clear) begin
        cal_acc <= '0;
        cal_cnt <= '0;
      end else if (cal_accum) begin
        cal_acc <= cal_sum;
        cal_cnt <= cal_cnt + CAL_ONE;
      end
      if (cal_done) begin
        offset_out <= cal_sum[ACC_W-1:CAL_LOG2];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample datapath: offset removal recentred on mid-scale, clamped to range.
  // --------------------------------------------------------------------------
  logic signed [DATA_W+1:0] run_diff;
  logic [DATA_W-1:0]        run_value;

  assign run_diff = $signed({2'b00, sample_in}) - $signed({2'b00, offset_out}) + MID_S;

  // Saturate the recentred sample instead of letting it wrap.
  always_comb begin
    run_value = run_diff[DATA_W-1:0];
    if (run_diff[DATA_W+1]) begin
      run_value = '0;
    end else if (run_diff > MAX_S) begin
      run_value = '1;
    end
  end

  // Output register: one result per valid sample, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sample_valid;
      if (sample_valid) begin
        case (state)
          ST_AC_CAL: result <= MID_U;
          ST_AC_RUN: result <= run_value;
          default:   result <= sample_in;
        endcase
      end
    end
  end

  // Registered state decodes, aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_ac  <= 1'b0;
      cal_busy <= 1'b0;
    end else begin
      mode_ac  <= (state_nxt != ST_DC);
      cal_busy <= (state_nxt == ST_AC_CAL);
    end
  end

endmodule
`default_nettype wire
